// File: rtl/th_mem_arbiter.sv
// th_mem_arbiter
//   Shares one read-only memory port between two requesters. Port A is the
//   second-level instruction fetch refill master and port B is the data load
//   master. Grants are round-robin. The owner keeps the grant for a burst of at
//   most MAXBURST accepted beats. A tag FIFO remembers which port issued each
//   outstanding beat, so every returning data word is steered to that port.
//
// Ports
//   clock_i, reset_i           clock, asynchronous active-high reset
//   a_read_i/a_addr_i          port A request and address (held until rack)
//   a_rack_o/a_ready_o/a_data_o port A accept, data valid, data
//   b_*                        same as port A, for port B
//   m_read_o/m_addr_o          forwarded request to memory
//   m_rack_i/m_ready_i/m_data_i memory accept, data valid, data
//   owner_o                    current grant: 00 idle, 01 A, 10 B
//   err_o                      sticky flag: memory returned data with no beat outstanding
module th_mem_arbiter #(
  parameter int ADDRESS  = 10,
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int MAXBURST = 8
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               a_read_i,
  output logic               a_rack_o,
  output logic               a_ready_o,
  input  logic [ADDRESS-1:0] a_addr_i,
  output logic [WIDTH-1:0]   a_data_o,
  input  logic               b_read_i,
  output logic               b_rack_o,
  output logic               b_ready_o,
  input  logic [ADDRESS-1:0] b_addr_i,
  output logic [WIDTH-1:0]   b_data_o,
  output logic               m_read_o,
  input  logic               m_rack_i,
  input  logic               m_ready_i,
  output logic [ADDRESS-1:0] m_addr_o,
  input  logic [WIDTH-1:0]   m_data_i,
  output logic [1:0]         owner_o,
  output logic               err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(MAXBURST + 1);

  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAXBURST - 1);

  // State encoding doubles as the owner_o value.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;       // 1: B held the most recent grant
  logic [BW-1:0] beat_q, beat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          err_q;
  logic          tags_q [DEPTH];       // 1: beat belongs to B

  logic own_a, own_b;
  logic self_read, other_read;
  logic full, empty;
  logic accept, pop, head_b;
  logic grant_end;

  // Forwarding and return steering
  always_comb begin
    own_a      = (state_q == OWN_A);
    own_b      = (state_q == OWN_B);
    self_read  = (own_a & a_read_i) | (own_b & b_read_i);
    other_read = (own_a & b_read_i) | (own_b & a_read_i);
    full       = (cnt_q == CNT_FULL);
    empty      = (cnt_q == '0);

    // A full FIFO blocks the request even if a pop happens this cycle.
    m_read_o   = self_read & ~full;
    m_addr_o   = own_b ? b_addr_i : a_addr_i;
    accept     = m_read_o & m_rack_i;
    a_rack_o   = accept & own_a;
    b_rack_o   = accept & own_b;

    pop        = m_ready_i & ~empty;
    head_b     = tags_q[rd_ptr_q];
    a_ready_o  = pop & ~head_b;
    b_ready_o  = pop & head_b;
    a_data_o   = m_data_i;
    b_data_o   = m_data_i;
  end

  // Grant arbitration and occupancy
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    beat_d    = beat_q;
    grant_end = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On a tie the port that did not hold the last grant wins.
        if (a_read_i && (!b_read_i || last_q)) state_d = OWN_A;
        else if (b_read_i)                     state_d = OWN_B;
      end
      OWN_A, OWN_B: begin
        // Stalled cycles (full FIFO) keep the grant and do not count as beats.
        grant_end = ~self_read | (accept & (beat_q == BEAT_LAST));
        if (grant_end) begin
          last_d = own_b;
          beat_d = '0;
          if (other_read)     state_d = own_a ? OWN_B : OWN_A;
          else if (self_read) state_d = state_q;
          else                state_d = IDLE;
        end else if (accept) begin
          beat_d = beat_q + BEAT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    unique case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      beat_q   <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      if (accept)             wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)                rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (m_ready_i && empty) err_q    <= 1'b1;
    end
  end

  // Tag storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clock_i) begin
    if (accept) tags_q[wr_ptr_q] <= own_b;
  end

  assign owner_o = state_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_th_mem_arbiter.sv
module tb_th_mem_arbiter;
  localparam int ADDRESS  = 10;
  localparam int WIDTH    = 32;
  localparam int DEPTH    = 4;
  localparam int MAXBURST = 8;

  logic               clock_i = 1'b0;
  logic               reset_i = 1'b1;
  logic               a_read_i = 1'b0;
  logic               a_rack_o, a_ready_o;
  logic [ADDRESS-1:0] a_addr_i = '0;
  logic [WIDTH-1:0]   a_data_o;
  logic               b_read_i = 1'b0;
  logic               b_rack_o, b_ready_o;
  logic [ADDRESS-1:0] b_addr_i = '0;
  logic [WIDTH-1:0]   b_data_o;
  logic               m_read_o;
  logic               m_rack_i = 1'b1;
  logic               m_ready_i = 1'b0;
  logic [ADDRESS-1:0] m_addr_o;
  logic [WIDTH-1:0]   m_data_i = '0;
  logic [1:0]         owner_o;
  logic               err_o;

  th_mem_arbiter #(
    .ADDRESS(ADDRESS), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAXBURST(MAXBURST)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .a_read_i(a_read_i), .a_rack_o(a_rack_o), .a_ready_o(a_ready_o),
    .a_addr_i(a_addr_i), .a_data_o(a_data_o),
    .b_read_i(b_read_i), .b_rack_o(b_rack_o), .b_ready_o(b_ready_o),
    .b_addr_i(b_addr_i), .b_data_o(b_data_o),
    .m_read_o(m_read_o), .m_rack_i(m_rack_i), .m_ready_i(m_ready_i),
    .m_addr_o(m_addr_o), .m_data_i(m_data_i),
    .owner_o(owner_o), .err_o(err_o)
  );

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Memory contents: word at address a is 0x1000_0000 + a - 5.
  function automatic logic [WIDTH-1:0] mdata(input logic [ADDRESS-1:0] a);
    return 32'h1000_0000 + 32'(a) - 32'd5;
  endfunction

  // Scoreboard queues: expected data per port in issue order.
  logic [WIDTH-1:0] exp_a[$];
  logic [WIDTH-1:0] exp_b[$];

  // Observation logs (cleared per test).
  int rack_log[$];   // 0 = A, 1 = B
  int rack_cyc[$];
  int ready_cyc[$];
  int owner_log[$];
  logic [1:0] last_owner = 2'b00;

  function automatic int rk(input int i);
    if (i < rack_log.size()) return rack_log[i];
    return -1;
  endfunction
  function automatic int rc(input int i);
    if (i < rack_cyc.size()) return rack_cyc[i];
    return -1;
  endfunction
  function automatic int rdc(input int i);
    if (i < ready_cyc.size()) return ready_cyc[i];
    return -1;
  endfunction
  function automatic int ow(input int i);
    if (i < owner_log.size()) return owner_log[i];
    return -1;
  endfunction

  task automatic clear_logs();
    rack_log.delete();
    rack_cyc.delete();
    ready_cyc.delete();
    owner_log.delete();
  endtask

  // In-order memory model with per-beat latency.
  typedef struct {
    int               due;
    logic [WIDTH-1:0] data;
  } mresp_t;
  mresp_t memq[$];
  mresp_t mem_r;
  int  lat = 1;
  bit  lat_var = 1'b0;
  int  acc_n = 0;
  int  last_due = 0;
  int  mem_d;
  bit  spur = 1'b0;

  always @(negedge clock_i) begin
    if (m_read_o && m_rack_i) begin
      mem_d = cyc + (lat_var ? 1 + (acc_n % 3) : lat);
      if (mem_d <= last_due) mem_d = last_due + 1;
      last_due = mem_d;
      acc_n++;
      mem_r.due  = mem_d;
      mem_r.data = mdata(m_addr_o);
      memq.push_back(mem_r);
    end
  end

  always @(posedge clock_i) begin
    #1;
    if (memq.size() != 0 && memq[0].due <= cyc) begin
      m_ready_i = 1'b1;
      m_data_i  = memq[0].data;
      void'(memq.pop_front());
    end else begin
      m_ready_i = spur;
      m_data_i  = 32'hDEAD_BEEF;
    end
  end

  // Monitor: pops and compares whenever the DUT presents returned data.
  always @(negedge clock_i) begin
    if (a_rack_o) begin rack_log.push_back(0); rack_cyc.push_back(cyc); end
    if (b_rack_o) begin rack_log.push_back(1); rack_cyc.push_back(cyc); end
    if (a_rack_o && b_rack_o) check("both_rack", 64'({a_rack_o, b_rack_o}), 64'h1);
    if (owner_o != last_owner) begin
      owner_log.push_back(int'(owner_o));
      last_owner = owner_o;
    end
    if (a_ready_o || b_ready_o) ready_cyc.push_back(cyc);
    if (a_ready_o) begin
      if (exp_a.size() == 0) check("a_ready_unexpected", 64'(a_ready_o), 0);
      else check("a_data", 64'(a_data_o), 64'(exp_a.pop_front()));
    end
    if (b_ready_o) begin
      if (exp_b.size() == 0) check("b_ready_unexpected", 64'(b_ready_o), 0);
      else check("b_data", 64'(b_data_o), 64'(exp_b.pop_front()));
    end
  end

  // Issue n consecutive beats on one port, holding read high between beats.
  task automatic issue(input bit port_b, input int n, input logic [ADDRESS-1:0] base);
    for (int i = 0; i < n; i++) begin
      int t;
      logic [ADDRESS-1:0] ad;
      logic rk_seen;
      ad = base + ADDRESS'(i);
      if (port_b) begin b_addr_i = ad; b_read_i = 1'b1; exp_b.push_back(mdata(ad)); end
      else        begin a_addr_i = ad; a_read_i = 1'b1; exp_a.push_back(mdata(ad)); end
      t = 0;
      do begin
        @(negedge clock_i);
        t++;
        rk_seen = port_b ? b_rack_o : a_rack_o;
      end while (!rk_seen && t < 300);
      if (!rk_seen) check(port_b ? "b_rack_timeout" : "a_rack_timeout", 64'(rk_seen), 1);
      @(posedge clock_i); #1;
    end
    if (port_b) b_read_i = 1'b0;
    else        a_read_i = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((memq.size() != 0 || exp_a.size() != 0 || exp_b.size() != 0) && t < 300) begin
      @(posedge clock_i);
      t++;
    end
    repeat (3) @(posedge clock_i);
    #1;
    check("drain_exp_a", 64'(exp_a.size()), 0);
    check("drain_exp_b", 64'(exp_b.size()), 0);
  endtask

  task automatic do_reset();
    @(posedge clock_i); #2 reset_i = 1'b1;
    @(posedge clock_i); #1 reset_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_owner", 64'(owner_o), 0);
    check("rst_err", 64'(err_o), 0);
    check("rst_m_read", 64'(m_read_o), 0);
    check("rst_racks", 64'({a_rack_o, b_rack_o}), 0);
    check("rst_readys", 64'({a_ready_o, b_ready_o}), 0);
    @(posedge clock_i); #1 reset_i = 1'b0;

    // Single A read at 0x005
    @(posedge clock_i); #1;
    clear_logs();
    a_addr_i = 10'h005;
    a_read_i = 1'b1;
    exp_a.push_back(32'h1000_0000);
    @(negedge clock_i);
    check("t1_owner_req_cycle", 64'(owner_o), 0);
    @(negedge clock_i);
    check("t1_owner_granted", 64'(owner_o), 2'b01);
    check("t1_a_rack", 64'(a_rack_o), 1);
    check("t1_m_addr", 64'(m_addr_o), 10'h005);
    @(posedge clock_i); #1 a_read_i = 1'b0;
    @(negedge clock_i);
    check("t1_a_ready", 64'(a_ready_o), 1);
    check("t1_b_ready", 64'(b_ready_o), 0);
    check("t1_a_data", 64'(a_data_o), 32'h1000_0000);
    @(negedge clock_i);
    check("t1_owner_idle", 64'(owner_o), 0);
    drain();
    check("t1_nracks", 64'(rack_log.size()), 1);

    // Tie after reset: A first, then B with no idle owner in between
    do_reset();
    clear_logs();
    fork
      issue(1'b0, 2, 10'h010);
      issue(1'b1, 2, 10'h210);
    join
    drain();
    check("t2_nracks", 64'(rack_log.size()), 4);
    check("t2_rack0", 64'(rk(0)), 0);
    check("t2_rack1", 64'(rk(1)), 0);
    check("t2_rack2", 64'(rk(2)), 1);
    check("t2_rack3", 64'(rk(3)), 1);
    check("t2_owner_seq0", 64'(ow(0)), 1);
    check("t2_owner_seq1", 64'(ow(1)), 2);
    check("t2_owner_seq2", 64'(ow(2)), 0);
    // A alone, then a tie from IDLE must go to B
    issue(1'b0, 1, 10'h020);
    drain();
    clear_logs();
    fork
      issue(1'b0, 1, 10'h030);
      issue(1'b1, 1, 10'h230);
    join
    drain();
    check("t2_tie2_first_b", 64'(rk(0)), 1);
    check("t2_tie2_then_a", 64'(rk(1)), 0);

    // Burst limit: A 20 beats, B 4 beats
    clear_logs();
    lat = 1;
    fork
      issue(1'b0, 20, 10'h080);
      begin @(posedge clock_i); #1; issue(1'b1, 4, 10'h280); end
    join
    drain();
    check("t3_nracks", 64'(rack_log.size()), 24);
    check("t3_a_8th", 64'(rk(7)), 0);
    check("t3_b_first", 64'(rk(8)), 1);
    check("t3_b_last", 64'(rk(11)), 1);
    check("t3_a_resume", 64'(rk(12)), 0);
    check("t3_a_last", 64'(rk(23)), 0);
    check("t3_handover_no_gap", 64'(rc(8)), 64'(rc(7) + 1));
    check("t3_self_regrant_no_gap", 64'(rc(20)), 64'(rc(19) + 1));

    // FIFO full stall with 6-cycle memory latency
    clear_logs();
    lat = 6;
    issue(1'b0, 6, 10'h0C0);
    drain();
    lat = 1;
    check("t4_four_back_to_back", 64'(rc(3)), 64'(rc(0) + 3));
    check("t4_first_ready", 64'(rdc(0)), 64'(rc(0) + 6));
    check("t4_fifth_after_ready", 64'(rc(4)), 64'(rdc(0) + 1));
    check("t4_sixth", 64'(rc(5)), 64'(rc(4) + 1));

    // Interleaved A/B with latency cycling 1..3
    clear_logs();
    lat_var = 1'b1;
    fork
      begin
        issue(1'b0, 3, 10'h040);
        repeat (2) @(posedge clock_i);
        #1;
        issue(1'b0, 3, 10'h060);
      end
      begin @(posedge clock_i); #1; issue(1'b1, 5, 10'h240); end
    join
    drain();
    lat_var = 1'b0;
    check("t5_nracks", 64'(rack_log.size()), 11);
    check("t5_nreadys", 64'(ready_cyc.size()), 11);

    // Spurious ready with empty FIFO
    lat = 6;
    @(negedge clock_i); spur = 1'b1;
    @(negedge clock_i);
    check("t6_spur_m_ready", 64'(m_ready_i), 1);
    check("t6_spur_no_ready", 64'({a_ready_o, b_ready_o}), 0);
    spur = 1'b0;
    @(negedge clock_i);
    check("t6_err_set", 64'(err_o), 1);
    repeat (3) @(negedge clock_i);
    check("t6_err_held", 64'(err_o), 1);

    // Asynchronous reset mid-burst
    @(posedge clock_i); #1;
    a_addr_i = 10'h0E0;
    a_read_i = 1'b1;
    repeat (3) @(negedge clock_i);
    check("t6_owner_mid_burst", 64'(owner_o), 2'b01);
    check("t6_m_read_mid_burst", 64'(m_read_o), 1);
    #2 reset_i = 1'b1;
    a_read_i = 1'b0;
    #1;
    check("t6_rst_err", 64'(err_o), 0);
    check("t6_rst_owner", 64'(owner_o), 0);
    check("t6_rst_m_read", 64'(m_read_o), 0);
    check("t6_rst_racks", 64'({a_rack_o, b_rack_o}), 0);
    @(posedge clock_i); #1 reset_i = 1'b0;
    repeat (10) @(negedge clock_i);
    check("t6_lost_beat_err", 64'(err_o), 1);
    check("t6_owner_idle", 64'(owner_o), 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
